uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one UART transmit path and its baud_gen instance among NUM_REQ clients.
//  Round-robin arbitration picks a client. The block loads that client's baud
//  rate into baud_gen, phase-restarts the generator, then serialises the byte as
//  an 8N1-style frame (start, DATA_W bits LSB first, one stop), one bit per baud tick.
//  Sits between client request logic and the baud_gen / TX pin.
// PARAMETERS
//  NUM_REQ  2  number of requesters, legal 2..4
//  DATA_W   8  data bits per frame, legal 5..8
// PORTS
//  clock      in   1                single clock, all logic on rising edge
//  rst        in   1                synchronous, active-high reset
//  req        in   NUM_REQ          per-client request; hold high until ack
//  req_data   in   NUM_REQ*DATA_W   client i byte at [i*DATA_W +: DATA_W]
//  req_baud   in   NUM_REQ*2        client i baud_rate code at [i*2 +: 2]
//  ack        out  NUM_REQ          one-hot, 1-cycle pulse: client's frame accepted
//  done       out  1                1-cycle pulse when stop bit completes
//  busy       out  1                high from ack cycle until done cycle
//  owner      out  2                index of current/last granted client
//  baud_rate  out  2                to baud_gen.baud_rate
//  baud_rst   out  1                to baud_gen.rst (holds generator in reset)
//  baud_in    in   1                from baud_gen.baud_out (square wave)
//  tx         out  1                serial line, idle high
// BEHAVIOUR
//  All outputs are registered.
//  Reset: tx=1, baud_rst=1, baud_rate=2'b00, ack=0, done=0, busy=0, owner=0,
//    rr pointer=0, state=IDLE.
//  Tick: baud_q <= baud_in; tick = baud_in & ~baud_q.
//    baud_q is forced 0 while baud_rst=1.
//  States: IDLE -> LOAD -> SYNC -> START -> DATA -> STOP -> IDLE.
//  IDLE, no req: hold. baud_rst=1, tx=1.
//  IDLE, any req: grant the first asserted req at or after the pointer, wrapping.
//    On that edge: ack[win]=1 for one cycle, busy=1, owner=win.
//    Capture req_data / req_baud of the winner.
//    baud_rate <= captured code; pointer <= (win+1) mod NUM_REQ; go LOAD.
//  LOAD: one cycle, baud_rst stays 1 so baud_gen restarts at count 0 with the new
//    divisor. Go SYNC; baud_rst <= 0.
//  SYNC: tx=1. On first tick: go START, tx <= 0.
//  START: on tick: go DATA, tx <= bit0, bit counter <= 0.
//  DATA: on tick: if counter == DATA_W-1, go STOP, tx <= 1.
//    Otherwise counter++, tx <= next bit.
//  STOP: on tick: go IDLE. done <= 1 (one cycle), busy <= 0, baud_rst <= 1.
//  Each bit lasts exactly one tick period; a frame is DATA_W+2 tick periods.
//  The scheduler does not depend on the divisor value.
//  Min one IDLE cycle between frames: a req high on the done cycle is arbitrated
//    on the next edge.
//  req deassert before ack: request withdrawn, no ack.
//  req changes after ack: ignored; data is already captured.
//  req/data changes while busy: ignored until IDLE.
//  Clients that still hold req after their ack are re-requesting. The pointer
//    guarantees no client waits more than NUM_REQ-1 frames.
//  rst mid-frame: next edge returns all reset values, tx=1. No done pulse.
//    The aborted frame is lost.
//  Unused upper owner bits are 0.
// STRUCTURE
//  Shared package uart_pkg:
//    BAUD_* codes 2'b00..2'b11 matching baud_gen divisors 20833/10417/5208/2604.
//    State encoding localparams ST_IDLE..ST_STOP.
//  One sub-module: uart_rr_arbiter (req, pointer -> one-hot grant, win index).
//    Combinational; the pointer register lives in the scheduler.
//  Shift register, bit counter and FSM stay in uart_tx_scheduler.
// TESTING
//  Bench drives baud_in as a square wave, period 8 clocks, held low while baud_rst=1.
//  1. Reset then req=01, req_data[7:0]=8'hA5, req_baud=2'b10:
//     ack=01 one cycle, baud_rate=2'b10.
//     tx seq 0,1,0,1,0,0,1,0,1,1, each exactly 8 clocks; then done one cycle.
//  2. req=11 held continuously: acks alternate 01,10,01,10; owner 0,1,0,1.
//     Each frame's tx matches that client's data.
//  3. Client1 baud 2'b11 then client0 baud 2'b00:
//     baud_rate updates in the LOAD cycle.
//     baud_rst is high for at least 2 cycles between frames.
//  4. rst asserted during DATA bit 3: next cycle tx=1, busy=0, baud_rst=1, no done.
//     A new req=01 after reset is granted (pointer back to 0).
//  5. req=10 pulsed during a busy frame then dropped: no ack[1].
//     req=10 rising in the done cycle is acked on the following edge.
//  6. NUM_REQ=3, DATA_W=5, all req high: grant order 0,1,2,0.
//     Frames are 7 tick periods long.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: baud_gen rate codes and transmit scheduler state encoding
package uart_pkg;
  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_SYNC  = 3'd2;
  localparam logic [2:0] ST_START = 3'd3;
  localparam logic [2:0] ST_DATA  = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;
endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational round-robin pick of the first request at or after ptr
module uart_rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         win,
  output logic               any
);
  logic [NUM_REQ-1:0] rot;
  logic [1:0]         off;
  logic [2:0]         sum;
  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) if (rot[k]) off = 2'(k);
    sum = {1'b0, ptr} + {1'b0, off};
    win = sum >= 3'(NUM_REQ) ? 2'(sum - 3'(NUM_REQ)) : sum[1:0];
    any = |req;
    grant = any ? NUM_REQ'(1) << win : '0;
  end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one baud_gen and UART TX line among clients
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]      req_baud,
  output logic [NUM_REQ-1:0]        ack,
  output logic                      done,
  output logic                      busy,
  output logic [1:0]                owner,
  output logic [1:0]                baud_rate,
  output logic                      baud_rst,
  input  logic                      baud_in,
  output logic                      tx
);
  localparam int CW = $clog2(DATA_W);
  logic [2:0]         state;
  logic [1:0]         ptr, win, ptr_nxt, sel_baud;
  logic [NUM_REQ-1:0] grant;
  logic               any, baud_q, tick;
  logic [DATA_W-1:0]  shreg, sel_data;
  logic [CW-1:0]      cnt;
  uart_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (grant),
    .win   (win),
    .any   (any)
  );
  assign tick    = baud_in & ~baud_q;
  assign ptr_nxt = (win == 2'(NUM_REQ - 1)) ? 2'b00 : win + 2'b01;
  always_comb begin
    sel_data = '0;
    sel_baud = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == 2'(i)) begin
        sel_data = req_data[i*DATA_W +: DATA_W];
        sel_baud = req_baud[i*2 +: 2];
      end
    end
  end
  // baud_rst stays high through LOAD so the generator restarts with the new divisor
  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      ack       <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      owner     <= '0;
      baud_rate <= BAUD_2400;
      baud_rst  <= 1'b1;
      baud_q    <= 1'b0;
      tx        <= 1'b1;
      shreg     <= '0;
      cnt       <= '0;
    end else begin
      ack    <= '0;
      done   <= 1'b0;
      baud_q <= baud_rst ? 1'b0 : baud_in;
      case (state)
        ST_IDLE: if (any) begin
          ack       <= grant;
          busy      <= 1'b1;
          owner     <= win;
          shreg     <= sel_data;
          baud_rate <= sel_baud;
          ptr       <= ptr_nxt;
          state     <= ST_LOAD;
        end
        ST_LOAD: begin
          baud_rst <= 1'b0;
          state    <= ST_SYNC;
        end
        ST_SYNC: if (tick) begin
          tx    <= 1'b0;
          state <= ST_START;
        end
        ST_START: if (tick) begin
          tx    <= shreg[0];
          shreg <= shreg >> 1;
          cnt   <= '0;
          state <= ST_DATA;
        end
        ST_DATA: if (tick) begin
          if (cnt == CW'(DATA_W - 1)) begin
            tx    <= 1'b1;
            state <= ST_STOP;
          end else begin
            cnt   <= cnt + 1'b1;
            tx    <= shreg[0];
            shreg <= shreg >> 1;
          end
        end
        ST_STOP: if (tick) begin
          done     <= 1'b1;
          busy     <= 1'b0;
          baud_rst <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: randomized scoreboard bench with a frame-level reference model
module tb_uart_tx_scheduler;
  localparam int NR = 2, DW = 8, P = 8;
  localparam int NR3 = 3, DW3 = 5;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, rst3 = 1'b1;
  logic [NR-1:0] req = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR*2-1:0] req_baud = '0;
  logic [NR-1:0] ack;
  logic done, busy, baud_rst, baud_in, tx;
  logic [1:0] owner, baud_rate;
  logic [2:0] bcnt = '0;
  always @(posedge clk) bcnt <= baud_rst ? 3'd0 : bcnt + 3'd1;
  assign baud_in = bcnt[2];
  uart_tx_scheduler #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clock(clk), .rst(rst), .req(req), .req_data(req_data), .req_baud(req_baud),
    .ack(ack), .done(done), .busy(busy), .owner(owner), .baud_rate(baud_rate),
    .baud_rst(baud_rst), .baud_in(baud_in), .tx(tx));
  logic [NR3-1:0] req3 = '1, ack3;
  logic [NR3*DW3-1:0] data3 = {5'h1B, 5'h06, 5'h15};
  logic [NR3*2-1:0] baud3 = 6'b01_11_00;
  logic done3, busy3, baud_rst3, baud_in3, tx3;
  logic [1:0] owner3, baud_rate3;
  logic [2:0] bcnt3 = '0;
  always @(posedge clk) bcnt3 <= baud_rst3 ? 3'd0 : bcnt3 + 3'd1;
  assign baud_in3 = bcnt3[2];
  uart_tx_scheduler #(.NUM_REQ(NR3), .DATA_W(DW3)) u3 (
    .clock(clk), .rst(rst3), .req(req3), .req_data(data3), .req_baud(baud3),
    .ack(ack3), .done(done3), .busy(busy3), .owner(owner3), .baud_rate(baud_rate3),
    .baud_rst(baud_rst3), .baud_in(baud_in3), .tx(tx3));
  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  typedef struct {logic [DW-1:0] data; logic [1:0] baud;} frame_t;
  frame_t exp_q[$];
  frame_t cur;
  logic [NR-1:0] req_p = '0;
  logic [NR*DW-1:0] data_p = '0;
  logic [NR*2-1:0] baud_p = '0;
  logic rst_p = 1'b1;
  bit m_idle = 1, dec_on = 0;
  int m_ptr = 0, dec_c = 0, dec_err = 0;
  // Reference model: who should win at each edge, and the exact waveform of each granted frame
  always @(negedge clk) begin
    logic [NR-1:0] eack;
    int w, b;
    logic ebit;
    if (rst_p) begin
      m_idle = 1; m_ptr = 0; dec_on = 0;
      exp_q.delete();
    end else begin
      eack = '0;
      w = -1;
      if (m_idle && |req_p) begin
        for (int k = 0; k < NR; k++) if (w < 0 && req_p[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
        eack[w] = 1'b1;
      end
      if (eack != '0 || ack != '0) begin
        chk("ack", ack, eack);
        if (eack != '0) begin
          chk("owner", owner, w);
          chk("busy_on_ack", busy, 1);
          chk("baud_rst_in_load", baud_rst, 1);
          chk("baud_rate_in_load", baud_rate, baud_p[w*2 +: 2]);
          exp_q.push_back('{data: data_p[w*DW +: DW], baud: baud_p[w*2 +: 2]});
          m_ptr = (w + 1) % NR;
          m_idle = 0;
        end
      end
      if (!dec_on && tx == 1'b0) begin
        if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
        else begin
          cur = exp_q.pop_front();
          dec_on = 1; dec_c = 0; dec_err = 0;
        end
      end
      if (dec_on) begin
        if (dec_c < P * (DW + 2)) begin
          b = dec_c / P;
          ebit = (b == 0) ? 1'b0 : (b <= DW) ? cur.data[b-1] : 1'b1;
          if (tx !== ebit || busy !== 1'b1 || baud_rst !== 1'b0 || done !== 1'b0) dec_err++;
          dec_c++;
        end else begin
          chk("frame_waveform", dec_err, 0);
          chk("done_at_stop_end", done, 1);
          chk("busy_off_at_done", busy, 0);
          chk("frame_baud", baud_rate, cur.baud);
          dec_on = 0;
          m_idle = 1;
        end
      end else if (done) chk("stray_done", done, 0);
    end
    rst_p = rst; req_p = req; data_p = req_data; baud_p = req_baud;
  end
  int ord3[$];
  logic [DW3-1:0] q3[$];
  logic [DW3-1:0] e3, got3;
  bit on3 = 0, rst3_p = 1;
  int c3 = 0;
  always @(negedge clk) begin
    int w3;
    if (rst3_p) on3 = 0;
    else begin
      if (ack3 != '0) begin
        w3 = 0;
        for (int k = 0; k < NR3; k++) if (ack3[k]) w3 = k;
        ord3.push_back(w3);
        q3.push_back(data3[w3*DW3 +: DW3]);
      end
      if (!on3 && tx3 == 1'b0) begin
        if (q3.size() == 0) chk("u3_unexpected_start", 1, 0);
        else begin
          e3 = q3.pop_front();
          on3 = 1; c3 = 0; got3 = '0;
        end
      end
      if (on3) begin
        if (c3 % P == 4 && c3 >= P + 4 && c3 <= P * DW3 + 4) got3[(c3 - P - 4) / P] = tx3;
        if (c3 == P * (DW3 + 1) + 4) chk("u3_stop_bit", tx3, 1);
        if (c3 == P * (DW3 + 2)) begin
          chk("u3_done_after_7_ticks", done3, 1);
          chk("u3_data", got3, e3);
          on3 = 0;
        end
        c3++;
      end
    end
    rst3_p = rst3;
  end
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic wait_ack(input int i, input string nm);
    int t = 0;
    while (!ack[i] && t < 1000) begin step(); t++; end
    chk(nm, ack[i], 1);
  endtask
  task automatic drain();
    int t = 0;
    req = '0;
    while ((busy || dec_on) && t < 3000) begin step(); t++; end
    if (t >= 3000) chk("drain_timeout", 0, 1);
    step(); step();
  endtask
  initial begin
    repeat (3) step();
    rst3 = 1'b0;
  end
  initial begin
    int t, got;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", tx, 1); chk("rst_baud_rst", baud_rst, 1); chk("rst_baud_rate", baud_rate, 0);
    chk("rst_ack", ack, 0); chk("rst_done", done, 0); chk("rst_busy", busy, 0); chk("rst_owner", owner, 0);
    @(posedge clk); #2 rst = 1'b0;
    step();
    req_data[7:0] = 8'hA5; req_baud[1:0] = 2'b10; req = 2'b01;
    wait_ack(0, "p1_ack0");
    chk("p1_ack_onehot", ack, 2'b01);
    chk("p1_baud", baud_rate, 2'b10);
    drain();
    req_data[15:8] = 8'h3C; req_baud[3:2] = 2'b11; req = 2'b10;
    wait_ack(1, "p3_ack1");
    chk("p3_baud_c1", baud_rate, 2'b11);
    drain();
    req_data = {8'h69, 8'hD2}; req = 2'b11;
    got = 0; t = 0;
    while (got < 4 && t < 3000) begin
      step(); t++;
      if (ack != '0) begin
        chk("p2_ack", ack, (got % 2 == 0) ? 2'b01 : 2'b10);
        chk("p2_owner", owner, got % 2);
        got++;
        if (got == 4) req = '0;
      end
    end
    chk("p2_grants", got, 4);
    drain();
    req_data[7:0] = 8'h81; req_baud[1:0] = 2'b00; req = 2'b01;
    wait_ack(0, "p3_ack0");
    chk("p3_baud_c0", baud_rate, 2'b00);
    drain();
    req = 2'b01;
    wait_ack(0, "p5_ack0");
    req = '0;
    t = 0;
    while (!(dec_on && dec_c >= 20) && t < 1000) begin step(); t++; end
    req = 2'b10;
    repeat (3) step();
    req = '0;
    t = 0;
    while (!done && t < 2000) begin step(); t++; end
    chk("p5_done_seen", done, 1);
    req = 2'b10;
    step();
    chk("p5_late_ack", ack, 2'b10);
    drain();
    req_data[7:0] = 8'hF0; req = 2'b01;
    wait_ack(0, "p4_ack0");
    req = '0;
    t = 0;
    while (!(dec_on && dec_c >= P * 4 + 2) && t < 1000) begin step(); t++; end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("p4_tx", tx, 1); chk("p4_busy", busy, 0); chk("p4_baud_rst", baud_rst, 1); chk("p4_done", done, 0);
    @(posedge clk); #2 rst = 1'b0; req = 2'b11;
    step();
    chk("p4_ptr_reset", ack, 2'b01);
    req = '0;
    drain();
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (ack[i] && $urandom_range(0, 1) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 5) == 0) begin
          req[i] = 1'b1;
          req_data[i*DW +: DW] = DW'($urandom);
          req_baud[i*2 +: 2] = 2'($urandom);
        end else if (req[i] && !ack[i] && $urandom_range(0, 31) == 0) req[i] = 1'b0;
        if ($urandom_range(0, 15) == 0) req_data[i*DW +: DW] = DW'($urandom);
      end
      step();
    end
    drain();
    if (ord3.size() < 4) chk("u3_grants", ord3.size(), 4);
    else for (int i = 0; i < 4; i++) chk("u3_order", ord3[i], i % NR3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
